// File: rtl/comm_master_pkg.sv
// Shared types and constants for the logic-analyser command channel initiator.
package comm_pkg;

  // Command opcodes carried in cmd[15:14]
  typedef enum logic [1:0] {
    RD   = 2'b00,
    WR   = 2'b01,
    DUMP = 2'b10,
    RSVD = 2'b11
  } opcode_e;

  // Initiator sequencing states
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    HIGH      = 2'b01,
    LOW       = 2'b10,
    WAIT_RESP = 2'b11
  } state_e;

  // Response bytes returned by the analyser
  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] NEG_ACK = 8'hEE;

  // True when the opcode asks for a multi-byte channel dump
  function automatic logic is_dump(input logic [1:0] op);
    return (op == DUMP);
  endfunction

endpackage

// File: rtl/comm_master_uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// tx_done is combinational and fires in the last cycle of the stop bit so a
// follow-on trmt in that same cycle starts the next frame with no idle gap.
module uart_tx #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  logic        busy_q, busy_d;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [9:0]  shift_q, shift_d;
  logic        baud_end_s;

  assign baud_end_s = (baud_q == 12'(BAUD_DIV - 1));
  assign tx_done    = busy_q & baud_end_s & (bit_q == 4'd9);
  assign TX         = shift_q[0];

  // Next-state logic for baud timing, bit counting and the shift register
  always_comb begin
    busy_d  = busy_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (trmt) begin
      busy_d  = 1'b1;
      baud_d  = 12'd0;
      bit_d   = 4'd0;
      shift_d = {1'b1, tx_data, 1'b0};
    end else if (busy_q) begin
      if (baud_end_s) begin
        baud_d  = 12'd0;
        shift_d = {1'b1, shift_q[9:1]};
        if (bit_q == 4'd9) begin
          busy_d = 1'b0;
          bit_d  = 4'd0;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end else begin
        baud_d = baud_q + 12'd1;
      end
    end else begin
      baud_d = 12'd0;
    end
  end

  // Transmitter state registers; the line is forced idle-high on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      baud_q  <= 12'd0;
      bit_q   <= 4'd0;
      shift_q <= 10'h3FF;
    end else begin
      busy_q  <= busy_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/comm_master.sv
// Host-side command initiator: sends a 16-bit command as two UART frames
// (high byte first) and hands the analyser's response bytes to the host.
module comm_master
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604,
  parameter int unsigned ENTRIES  = 384,
  parameter int unsigned LOG2     = 9,
  parameter int unsigned TIMEOUT  = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        TX,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic        busy,
  output logic        cmd_cmplt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        resp_last,
  output logic        timeout
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      lo_q, lo_d;
  logic [LOG2-1:0] cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            busy_q, busy_d;
  logic            cmplt_q, cmplt_d;
  logic            tout_q, tout_d;
  logic [7:0]      resp_q, resp_d;
  logic            rrdy_q, rrdy_d;
  logic            rlast_q, rlast_d;

  logic            trmt_s;
  logic [7:0]      tx_data_s;
  logic            tx_done_s;
  logic            clr_s;
  logic [LOG2-1:0] exp_cnt_s;
  logic [LOG2-1:0] cnt_inc_s;

  // Only the low byte and opcode are needed after the accept cycle: the high
  // byte is handed straight to the transmitter as the command is latched.
  assign exp_cnt_s = is_dump(op_q) ? LOG2'(ENTRIES) : LOG2'(1);
  assign cnt_inc_s = cnt_q + LOG2'(1);

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt_s),
    .tx_data (tx_data_s),
    .TX      (TX),
    .tx_done (tx_done_s)
  );

  // Command sequencing, response collection and timeout supervision
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    busy_d    = busy_q;
    cmplt_d   = cmplt_q;
    tout_d    = tout_q;
    resp_d    = resp_q;
    rrdy_d    = 1'b0;
    rlast_d   = 1'b0;
    trmt_s    = 1'b0;
    tx_data_s = lo_q;
    clr_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (snd_cmd && !busy_q) begin
          op_d      = cmd[15:14];
          lo_d      = cmd[7:0];
          cnt_d     = '0;
          cmplt_d   = 1'b0;
          tout_d    = 1'b0;
          busy_d    = 1'b1;
          trmt_s    = 1'b1;
          tx_data_s = cmd[15:8];
          state_d   = HIGH;
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (tx_done_s) begin
          trmt_s  = 1'b1;
          state_d = LOW;
        end else begin
          state_d = HIGH;
        end
      end
      LOW: begin
        if (tx_done_s) begin
          cmplt_d = 1'b1;
          tmr_d   = '0;
          state_d = WAIT_RESP;
        end else begin
          state_d = LOW;
        end
      end
      WAIT_RESP: begin
        if (rx_rdy) begin
          clr_s  = 1'b1;
          resp_d = rx_data;
          rrdy_d = 1'b1;
          cnt_d  = cnt_inc_s;
          tmr_d  = '0;
          if (cnt_inc_s == exp_cnt_s) begin
            rlast_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RESP;
          end
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      lo_q    <= 8'h00;
      cnt_q   <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      cmplt_q <= 1'b0;
      tout_q  <= 1'b0;
      resp_q  <= 8'h00;
      rrdy_q  <= 1'b0;
      rlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      busy_q  <= busy_d;
      cmplt_q <= cmplt_d;
      tout_q  <= tout_d;
      resp_q  <= resp_d;
      rrdy_q  <= rrdy_d;
      rlast_q <= rlast_d;
    end
  end

  // clr_rx_rdy must consume the byte in the cycle rx_rdy is seen
  assign clr_rx_rdy = clr_s;
  assign busy       = busy_q;
  assign cmd_cmplt  = cmplt_q;
  assign timeout    = tout_q;
  assign resp       = resp_q;
  assign resp_rdy   = rrdy_q;
  assign resp_last  = rlast_q;

endmodule

// File: tb/tb_comm_master.sv
// Self-checking bench for comm_master: table of commands, serial decode of TX,
// response scoreboard, plus timeout, busy-drop and mid-frame reset sequences.
module tb_comm_master;
  import comm_pkg::*;

  localparam int unsigned BD  = 8;
  localparam int unsigned TO  = 500;
  localparam int unsigned ENT = 384;
  localparam int unsigned L2  = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        snd_cmd = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy = 1'b0;
  logic        TX, clr_rx_rdy, busy, cmd_cmplt, resp_rdy, resp_last, timeout;
  logic [7:0]  resp;

  always #5 clk = ~clk;

  comm_master #(.BAUD_DIV(BD), .ENTRIES(ENT), .LOG2(L2), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd), .TX(TX),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy), .busy(busy),
    .cmd_cmplt(cmd_cmplt), .resp(resp), .resp_rdy(resp_rdy),
    .resp_last(resp_last), .timeout(timeout)
  );

  typedef struct { logic [7:0] b; logic last; } sb_t;
  typedef struct { logic [15:0] cmd; int nresp; logic [7:0] base; logic inject; logic early; } vec_t;

  sb_t        sb_q[$];
  sb_t        mon_e;
  vec_t       vt[6];
  int         n_vec = 0;
  int         n_miss = 0;
  logic [7:0] last_resp = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every resp_rdy pulse must match the oldest outstanding byte
  always @(negedge clk) begin
    if (rst_n && resp_rdy) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_resp_rdy: resp=%0h with no byte outstanding", resp);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp", 32'(resp), 32'(mon_e.b));
        chk("resp_last", 32'(resp_last), 32'(mon_e.last));
      end
    end
  end

  task automatic send_cmd(input logic [15:0] c, input logic inject, input logic early, input logic [7:0] eb);
    logic [159:0] txs;
    logic [9:0]   f;
    logic [7:0]   by, hi, lo;
    int bad_wave = 0;
    int early_cmplt = 0;
    int early_clr = 0;
    int not_busy = 0;
    @(negedge clk);
    cmd = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    chk("timeout_cleared", 32'(timeout), 32'd0);
    for (int n = 0; n < 160; n++) begin
      if (n > 0) @(negedge clk);
      txs[n] = TX;
      if (cmd_cmplt) early_cmplt++;
      if (clr_rx_rdy) early_clr++;
      if (!busy) not_busy++;
      if (inject && n == 50) begin cmd = 16'hFFFF; snd_cmd = 1'b1; end
      if (inject && n == 51) snd_cmd = 1'b0;
      if (early && n == 20) begin
        rx_data = eb;
        rx_rdy = 1'b1;
        sb_q.push_back('{eb, 1'b1});
        last_resp = eb;
      end
    end
    @(negedge clk);
    chk("cmd_cmplt_at_160", 32'(cmd_cmplt), 32'd1);
    chk("busy_in_wait", 32'(busy), 32'd1);
    chk("tx_idle_after", 32'(TX), 32'd1);
    chk("cmd_cmplt_early", 32'(early_cmplt), 32'd0);
    chk("clr_during_tx", 32'(early_clr), 32'd0);
    chk("busy_during_tx", 32'(not_busy), 32'd0);
    for (int n = 0; n < 160; n++) begin
      by = (n < 80) ? c[15:8] : c[7:0];
      f = {1'b1, by, 1'b0};
      if (txs[n] !== f[(n % 80) / 8]) bad_wave++;
    end
    chk("tx_wave", 32'(bad_wave), 32'd0);
    for (int k = 0; k < 8; k++) begin
      hi[k] = txs[8 * (k + 1) + 4];
      lo[k] = txs[80 + 8 * (k + 1) + 4];
    end
    chk("tx_hi_byte", 32'(hi), 32'(c[15:8]));
    chk("tx_lo_byte", 32'(lo), 32'(c[7:0]));
  endtask

  task automatic respond(input logic [7:0] b, input logic last, input logic already);
    int w = 0;
    if (!already) begin
      rx_data = b;
      rx_rdy = 1'b1;
      sb_q.push_back('{b, last});
      last_resp = b;
    end
    #1;
    while (!clr_rx_rdy && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    chk("clr_rx_rdy_seen", 32'(clr_rx_rdy), 32'd1);
    @(negedge clk);
    rx_rdy = 1'b0;
    chk("busy_after_byte", 32'(busy), 32'(!last));
  endtask

  initial begin
    int c;
    int tx_low;
    logic [7:0] bb;
    vt[0] = '{16'h4B55, 1,   POS_ACK, 1'b0, 1'b0};
    vt[1] = '{16'h8100, 384, 8'h00,   1'b0, 1'b0};
    vt[2] = '{16'h0B55, 0,   8'h00,   1'b0, 1'b0};
    vt[3] = '{16'h4B55, 1,   NEG_ACK, 1'b1, 1'b0};
    vt[4] = '{16'hC3A5, 1,   NEG_ACK, 1'b0, 1'b0};
    vt[5] = '{16'h0012, 1,   8'h3C,   1'b0, 1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_cmplt", 32'(cmd_cmplt), 32'd0);
    chk("rst_resp_rdy", 32'(resp_rdy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      send_cmd(vt[i].cmd, vt[i].inject, vt[i].early, vt[i].base);
      if (vt[i].nresp == 0) begin
        c = 0;
        while (!timeout && c < 700) begin
          @(negedge clk);
          c++;
        end
        chk("timeout_latency", 32'(c), 32'd500);
        chk("busy_after_timeout", 32'(busy), 32'd0);
        chk("resp_kept_on_timeout", 32'(resp), 32'(last_resp));
        repeat (5) @(negedge clk);
        chk("timeout_sticky", 32'(timeout), 32'd1);
      end else begin
        for (int j = 0; j < vt[i].nresp; j++) begin
          bb = vt[i].base + 8'(j);
          respond(bb, (j == vt[i].nresp - 1), (vt[i].early && j == 0));
        end
        @(negedge clk);
        chk("resp_hold", 32'(resp), 32'(last_resp));
      end
    end

    // Mid-frame reset: TX low inside the high frame, then reset asynchronously
    @(negedge clk);
    cmd = 16'h0000;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (30) @(negedge clk);
    chk("tx_low_midframe", 32'(TX), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(TX), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_resp", 32'(resp), 32'd0);
    chk("arst_resp_rdy", 32'(resp_rdy), 32'd0);
    chk("arst_resp_last", 32'(resp_last), 32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    chk("arst_cmd_cmplt", 32'(cmd_cmplt), 32'd0);
    chk("arst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_low = 0;
    repeat (200) begin
      @(negedge clk);
      if (!TX) tx_low++;
    end
    chk("tx_idle_after_reset", 32'(tx_low), 32'd0);
    chk("busy_idle_after_reset", 32'(busy), 32'd0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/comm_master.md
Name: comm_master

Overview:
- Host-side initiator for the logic-analyser command channel.
- Takes a 16-bit command and serialises it on TX as two 8N1 UART frames, high byte first. It then collects the response bytes arriving from the existing byte-level UART receiver and presents them one at a time to the host logic.
- Responses are one byte for register read/write/bad commands. A channel dump (opcode 2'b10) returns ENTRIES bytes.
- Sits between the host-side control/test logic and the serial line feeding the analyser's command receiver.

Parameters:
- BAUD_DIV, 2604: clock cycles per UART bit (50 MHz / 19200 baud); width 12 bits.
- ENTRIES, 384: bytes returned by a dump command.
- LOG2, 9: width of the dump byte counter.
- TIMEOUT, 1000000: max idle cycles allowed between command completion and each expected response byte.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  16  command; [15:14] opcode
- snd_cmd  in  1  one-cycle request to send cmd; ignored unless idle
- TX  out  1  serial line to analyser; idles high
- rx_data  in  8  byte from UART receiver
- rx_rdy  in  1  rx_data valid; level, held until cleared
- clr_rx_rdy  out  1  one-cycle pulse consuming rx_data
- busy  out  1  high from accepted snd_cmd until final response or timeout
- cmd_cmplt  out  1  high once both command bytes are shifted out; cleared by next accepted snd_cmd
- resp  out  8  latest response byte
- resp_rdy  out  1  one-cycle pulse when resp updates
- resp_last  out  1  asserted with resp_rdy on the final expected byte
- timeout  out  1  sticky error; set on response timeout, cleared by next accepted snd_cmd

Behaviour:
- Reset (async, rst_n low): state IDLE, TX=1, all other outputs 0, counters 0.
- Reset mid-frame aborts the transfer. TX returns high immediately.
- snd_cmd accepted only in IDLE with busy=0. The accept cycle latches cmd and clears cmd_cmplt, timeout and the byte counter. busy rises on the following edge.
- State HIGH: send cmd[15:8] via uart_tx.
- State LOW: send cmd[7:0]. The low byte starts on the cycle after the high frame's stop bit ends, so there is no extra idle gap.
- After the low frame's stop bit: set cmd_cmplt and enter WAIT_RESP.
- Frame format, LSB first:
  - start bit 0, then 8 data bits, then stop bit 1;
  - each bit lasts exactly BAUD_DIV cycles;
  - one frame is 10*BAUD_DIV cycles.
- Expected response count: ENTRIES if the latched opcode is 2'b10, else 1.
- WAIT_RESP, when rx_rdy=1:
  - same cycle: pulse clr_rx_rdy;
  - next cycle: resp<=rx_data, resp_rdy pulse, count increments;
  - when count reaches the expected value, assert resp_last with that resp_rdy and go to IDLE (busy falls the same edge).
- rx_rdy is sampled only in WAIT_RESP. Bytes arriving while the command is still transmitting are left pending and consumed after entering WAIT_RESP.
- Timeout counter resets on entry to WAIT_RESP and on each consumed byte. At TIMEOUT cycles without rx_rdy: set timeout, return to IDLE, leave resp unchanged, assert no resp_rdy.
- Dump byte counter is LOG2 bits. ENTRIES must be < 2^LOG2, and the counter never wraps within a command.
- snd_cmd while busy is dropped with no side effects.
- Simultaneous snd_cmd and timeout expiry: timeout is processed; the snd_cmd is dropped.

Decomposition:
- Package comm_pkg holds:
  - opcode enum: RD=2'b00, WR=2'b01, DUMP=2'b10, RSVD=2'b11;
  - state enum: IDLE, HIGH, LOW, WAIT_RESP;
  - response constants POS_ACK=8'hA5, NEG_ACK=8'hEE, for bench checks.
- One sub-module, uart_tx:
  - inputs trmt, tx_data; outputs TX, tx_done;
  - contains the baud counter, 4-bit bit counter and 10-bit shift register;
  - parameterised by BAUD_DIV.
- The comm_master FSM drives trmt for one cycle per byte and advances on tx_done.

Test Plan (BAUD_DIV=8, TIMEOUT=500 in bench):
- Reset released, no stimulus for 100 cycles -> TX=1; busy, cmd_cmplt, resp_rdy, timeout all 0.
- snd_cmd with cmd=16'h4B55 -> TX decodes to 0x4B then 0x55, each frame 80 cycles, no gap. cmd_cmplt rises after 160 cycles and busy stays 1.
- After the above, bench receiver model raises rx_rdy with rx_data=8'hA5 -> clr_rx_rdy pulses, resp=8'hA5, resp_rdy and resp_last pulse together, busy falls.
- cmd=16'h8100 (dump CH1), model returns bytes 0..383 mod 256 -> 384 resp_rdy pulses in order. resp_last only on the 384th, with resp=8'h7F.
- cmd=16'h0B55 with no response -> timeout=1 500 cycles after cmd_cmplt, busy falls, no resp_rdy. Next snd_cmd clears timeout.
- Two further cases:
  - snd_cmd pulsed mid-transmission with cmd=16'hFFFF -> ignored; TX continues the original bytes.
  - rst_n dropped mid-frame -> TX=1 and all outputs 0 immediately.
